// File: rtl/and_gate_if.sv
// and_gate_if: valid/ready bundle for the registered AND unit.
//   in_valid/in_ready/a/b      : operand pair handshake (producer -> unit)
//   out_valid/out_ready        : result handshake (unit -> consumer)
//   y/y_all/y_none             : registered result and its all-ones / all-zero flags
// master: the environment driving operands and consuming results.
// slave : the and_gate unit itself.
interface and_gate_if #(
  parameter int REG_WIDTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] a;
  logic [REG_WIDTH-1:0] b;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] y;
  logic                 y_all;
  logic                 y_none;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    input  out_valid,
    output out_ready,
    input  y,
    input  y_all,
    input  y_none
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    output out_valid,
    input  out_ready,
    output y,
    output y_all,
    output y_none
  );
endinterface

// File: rtl/and_gate.sv
// and_gate: single-stage registered bitwise AND with valid/ready on both sides.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears result, flags and out_valid
//   bus  : and_gate_if slave modport (operands in, result and flags out)
// One output register; a new pair can be accepted in the same cycle the held
// result is consumed, so a stream with out_ready high runs at one result/cycle.
module and_gate #(
  parameter int REG_WIDTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  and_gate_if.slave bus
);

  logic                 accept;
  logic [REG_WIDTH-1:0] y_next;

  // Register is free when empty or being drained this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign y_next       = bus.a & bus.b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.y         <= '0;
      bus.y_all     <= 1'b0;
      bus.y_none    <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.y         <= y_next;
      bus.y_all     <= &y_next;
      bus.y_none    <= ~|y_next;
    end else if (bus.out_ready) begin
      // Drain: data and flags keep their last values, only valid drops.
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
module tb_and_gate;
  localparam int W = 3;
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference model state: what the consumer should currently see.
  bit           m_valid;
  logic [W-1:0] m_y;
  bit           m_all;
  bit           m_none;

  // Current stimulus.
  bit           s_iv;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  bit           s_ordy;

  and_gate_if #(.REG_WIDTH(W)) bus ();

  and_gate #(.REG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] and_ref(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[i] && z[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_y     = '0;
    m_all   = 0;
    m_none  = 0;
  endtask

  // Effect of one rising edge on what the consumer sees.
  task automatic model_edge();
    bit space;
    space = !m_valid || s_ordy;
    if (s_iv && space) begin
      m_y     = and_ref(s_a, s_b);
      m_valid = 1;
      m_all   = (m_y == ALL_ONES);
      m_none  = (m_y == '0);
    end else if (m_valid && s_ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, ".y"},         32'(bus.y),         32'(m_y));
    check({tag, ".y_all"},     32'(bus.y_all),     32'(m_all));
    check({tag, ".y_none"},    32'(bus.y_none),    32'(m_none));
  endtask

  // Called just after a rising edge: drive, check in_ready, clock, check outputs.
  task automatic step(input string tag, input bit iv, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input bit ordy);
    s_iv = iv; s_a = av; s_b = bv; s_ordy = ordy;
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!m_valid || ordy));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check_outputs("reset");
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Truth table and width cases, one pair per cycle
    step("tt00", 1, 3'b000, 3'b000, 1);
    check("tt00.y_none_exact", 32'(bus.y_none), 32'd1);
    step("tt01", 1, 3'b000, 3'b001, 1);
    step("tt10", 1, 3'b001, 3'b000, 1);
    step("tt11", 1, 3'b001, 3'b001, 1);
    check("tt11.y_exact", 32'(bus.y), 32'(3'b001));
    step("full", 1, 3'b111, 3'b111, 1);
    check("full.y_all_exact", 32'(bus.y_all), 32'd1);
    step("mixed", 1, 3'b101, 3'b110, 1);
    check("mixed.y_exact", 32'(bus.y), 32'(3'b100));

    // Backpressure
    step("bp_load", 1, 3'b011, 3'b111, 1);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 1, 3'b111, 3'b111, 0);
      check("bp_hold.y_exact", 32'(bus.y), 32'(3'b011));
      check("bp_hold.in_ready_exact", 32'(bus.in_ready), 32'd0);
    end
    step("bp_release", 1, 3'b111, 3'b111, 1);
    check("bp_release.y_exact", 32'(bus.y), 32'(3'b111));

    // Drain keeps data, drops valid; idle operands are ignored
    step("drain", 0, 3'b010, 3'b010, 1);
    check("drain.y_kept", 32'(bus.y), 32'(3'b111));
    step("idle", 0, 3'b000, 3'b000, 0);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      step("stream", 1, ra, rb, 1);
      check("stream.valid_exact", 32'(bus.out_valid), 32'd1);
      check("stream.y_direct", 32'(bus.y), 32'(ra & rb));
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    // Reset mid-operation while holding 3'b101
    step("rm_load", 1, 3'b101, 3'b111, 1);
    step("rm_hold", 0, 3'b000, 3'b000, 0);
    check("rm_hold.y_exact", 32'(bus.y), 32'(3'b101));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("rm_async");
    check("rm_async.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("rm_after");
    step("rm_accept", 1, 3'b010, 3'b011, 1);
    check("rm_accept.y_exact", 32'(bus.y), 32'(3'b010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
